mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between the instruction cache (loads only) and the data cache (loads and stores).
- Picks one requester per cycle, drives the memory command, address and data, and routes the accept tag back to the requester it granted.
- Tracks which requester owns each outstanding load tag, so returning data reaches only its owner.
- Sits between icache/dcache and the memory model, in place of the direct cache-to-memory connection.

Parameters:
- NUM_TAGS, 16: memory tag space; tag 0 means "no tag".
- STARVE_LIMIT, 4: consecutive icache losses after which icache gets priority.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; state is cleared while reset==0.
- icache_command  in  2  BUS_NONE or BUS_LOAD.
- icache_addr  in  XLEN  icache request address, 8-byte aligned.
- dcache_command  in  2  BUS_NONE, BUS_LOAD or BUS_STORE.
- dcache_addr  in  XLEN  dcache request address.
- dcache_data  in  64  store data.
- mem_response  in  4  memory accept tag for this cycle's command; 0 means rejected.
- mem_data  in  64  returning load data.
- mem_tag  in  4  tag of returning data; 0 means none.
- proc2mem_command  out  2  command to memory.
- proc2mem_addr  out  XLEN  address to memory.
- proc2mem_data  out  64  store data to memory.
- icache_response  out  4  accept tag to icache.
- icache_tag  out  4  returning tag, icache-owned only.
- icache_mem_data  out  64  mem_data pass-through.
- dcache_response  out  4  accept tag to dcache.
- dcache_tag  out  4  returning tag, dcache-owned only.
- dcache_mem_data  out  64  mem_data pass-through.
- outstanding_cnt  out  5  number of valid owner-table entries.
- orphan_tag  out  1  pulse: mem_tag!=0 arrived with no owner entry.

Behaviour:
- Grant is combinational from the current commands and registered state:
  - If only one requester is active, it wins.
  - If both are active, dcache wins unless the icache_prio register is 1; then icache wins.
  - If neither is active, proc2mem_command=BUS_NONE and address/data are 0.
- Winner's command, address and data (data only from dcache) drive the memory outputs.
- mem_response goes to the winner's response output; the loser's response output is 0 that cycle.
- Starvation counter (3 bits, saturating at STARVE_LIMIT):
  - Increments on any cycle where icache requests and does not get a nonzero icache_response.
  - Clears when icache is accepted, or when icache_command==BUS_NONE.
  - icache_prio sets when the counter reaches STARVE_LIMIT; it clears on the cycle icache is accepted.
- Owner table: NUM_TAGS entries, each {valid, owner}, where owner 0 = icache and 1 = dcache.
  - On an accepted BUS_LOAD (mem_response!=0), the entry at mem_response is written with valid=1 and the winner's id.
  - Accepted stores are not recorded.
- Return path, when mem_tag!=0:
  - If the entry is valid, drive mem_tag on the owner's tag output (other tag output is 0) and clear the entry at the clock edge.
  - If the entry is invalid, both tag outputs are 0 and orphan_tag=1 that cycle.
- Both *_mem_data outputs always equal mem_data.
- Entry 0 is never written.
- Same-cycle return and re-issue of the same tag: the return is routed using the old owner, and the new write wins, leaving valid=1 with the new owner.
- outstanding_cnt equals the count of valid entries, registered; maximum value 15.
- Reset (reset==0, any cycle, including mid-transaction):
  - All table entries invalid, counter 0, icache_prio 0, outstanding_cnt 0.
  - Combinational outputs follow the grant rules with state cleared.
  - In-flight returns after reset deassertion are treated as orphans.
- Latency: request-to-memory and response routing are 0 cycles (combinational); table and priority updates take effect the next cycle.

Decomposition:
- Shared package (sys_defs) holds:
  - the BUS_NONE/BUS_LOAD/BUS_STORE encodings and XLEN;
  - a requester-id enum (REQ_ICACHE, REQ_DCACHE);
  - a tag-owner entry struct.
- Sub-module mem_tag_owner_table holds the NUM_TAGS entries with write, clear, lookup and count ports.
- Arbitration and starvation logic stay in the top level.

Test Plan:
- Only icache issues BUS_LOAD 0x1000; mem_response=3 → icache_response=3, dcache_response=0. Later mem_tag=3 → icache_tag=3, dcache_tag=0, outstanding_cnt goes 1 then 0.
- Both issue loads and memory accepts with tag 5 → dcache wins, proc2mem_addr=dcache_addr, dcache_response=5, icache_response=0.
- Both request continuously with mem_response=7 each cycle → dcache wins 4 cycles, icache wins cycle 5, then dcache priority resumes.
- dcache BUS_STORE 0x2000 with data 0xDEADBEEF, accepted with tag 2 → proc2mem_data correct, no table entry, outstanding_cnt unchanged. A later mem_tag=2 gives orphan_tag=1.
- Tag 4 returns for icache while dcache is accepted with tag 4 in the same cycle → icache_tag=4, the entry is now owned by dcache, and the next mem_tag=4 goes to dcache_tag.
- Assert reset=0 with 3 loads outstanding → outstanding_cnt=0 immediately on the next edge. Returns of those tags after release give orphan_tag=1 and no cache tag output.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus encodings, requester ids and the tag-owner entry used by the
// memory bus arbiter and its owner table.
package sys_defs;

  localparam int XLEN  = 64;
  localparam int TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } tag_entry_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-side bus signals of the arbiter. The slave modport
// is the arbiter's view; master is the caches plus memory model driving it.
interface mem_bus_arbiter_if;
  import sys_defs::*;

  bus_command_e          icache_command;
  logic [XLEN-1:0]       icache_addr;
  bus_command_e          dcache_command;
  logic [XLEN-1:0]       dcache_addr;
  logic [63:0]           dcache_data;
  logic [TAG_W-1:0]      mem_response;
  logic [63:0]           mem_data;
  logic [TAG_W-1:0]      mem_tag;

  bus_command_e          proc2mem_command;
  logic [XLEN-1:0]       proc2mem_addr;
  logic [63:0]           proc2mem_data;
  logic [TAG_W-1:0]      icache_response;
  logic [TAG_W-1:0]      icache_tag;
  logic [63:0]           icache_mem_data;
  logic [TAG_W-1:0]      dcache_response;
  logic [TAG_W-1:0]      dcache_tag;
  logic [63:0]           dcache_mem_data;

  modport slave (
    input  icache_command, icache_addr, dcache_command, dcache_addr,
           dcache_data, mem_response, mem_data, mem_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
           icache_response, icache_tag, icache_mem_data,
           dcache_response, dcache_tag, dcache_mem_data
  );

  modport master (
    output icache_command, icache_addr, dcache_command, dcache_addr,
           dcache_data, mem_response, mem_data, mem_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
           icache_response, icache_tag, icache_mem_data,
           dcache_response, dcache_tag, dcache_mem_data
  );

endinterface

// File: rtl/mem_bus_arbiter_owner_table.sv
// Records which requester owns each outstanding load tag. A write on the
// same tag as a clear wins, so a re-issued tag keeps the new owner.
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16,
  parameter int CNT_W    = $clog2(NUM_TAGS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  req_id_e          wr_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output tag_entry_t       lookup_entry,
  output logic [CNT_W-1:0] count
);

  tag_entry_t       entries_q [NUM_TAGS];
  tag_entry_t       entries_d [NUM_TAGS];
  logic [CNT_W-1:0] count_d;

  assign lookup_entry = entries_q[lookup_tag];

  // NOTE: every always_comb output gets a default first (here the current
  // table) so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    entries_d = entries_q;
    if (clr_en && clr_tag != '0) entries_d[clr_tag].valid = 1'b0;
    if (wr_en && wr_tag != '0)   entries_d[wr_tag] = '{valid: 1'b1, owner: wr_owner};
    count_d = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      count_d = count_d + {{(CNT_W-1){1'b0}}, entries_d[i].valid};
  end

  // NOTE: this storage is reset, unlike a data RAM, because stale valid bits
  // would misroute returns that arrive after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) entries_q[i] <= '{valid: 1'b0, owner: REQ_ICACHE};
      count <= '0;
    end else begin
      entries_q <= entries_d;
      count     <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between icache and dcache: combinational grant with
// starvation priority for icache, and tag-owner routing of returning data.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus,
  output logic [4:0]          outstanding_cnt,
  output logic                orphan_tag
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic       icache_req, dcache_req, grant_icache, icache_accepted;
  logic       load_accepted, ret_hit;
  logic [2:0] starve_q, starve_inc;
  logic       icache_prio_q;
  req_id_e    winner;
  tag_entry_t ret_entry;

  assign icache_req   = bus.icache_command != BUS_NONE;
  assign dcache_req   = bus.dcache_command != BUS_NONE;
  assign grant_icache = icache_req && (!dcache_req || icache_prio_q);

  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    bus.icache_response  = '0;
    bus.dcache_response  = '0;
    winner               = REQ_DCACHE;
    if (grant_icache) begin
      bus.proc2mem_command = bus.icache_command;
      bus.proc2mem_addr    = bus.icache_addr;
      bus.icache_response  = bus.mem_response;
      winner               = REQ_ICACHE;
    end else if (dcache_req) begin
      bus.proc2mem_command = bus.dcache_command;
      bus.proc2mem_addr    = bus.dcache_addr;
      bus.proc2mem_data    = bus.dcache_data;
      bus.dcache_response  = bus.mem_response;
    end
  end

  assign icache_accepted = grant_icache && bus.mem_response != '0;
  assign load_accepted   = bus.proc2mem_command == BUS_LOAD && bus.mem_response != '0;
  assign starve_inc      = (starve_q == STARVE_MAX) ? starve_q : starve_q + 3'd1;

  // Priority is raised together with the counter reaching the limit, so
  // icache wins on the very next contended cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q      <= '0;
      icache_prio_q <= 1'b0;
    end else if (!icache_req) begin
      starve_q <= '0;
    end else if (icache_accepted) begin
      starve_q      <= '0;
      icache_prio_q <= 1'b0;
    end else begin
      starve_q <= starve_inc;
      if (starve_inc == STARVE_MAX) icache_prio_q <= 1'b1;
    end
  end

  mem_tag_owner_table #(.NUM_TAGS(NUM_TAGS)) u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (load_accepted),
    .wr_tag       (bus.mem_response),
    .wr_owner     (winner),
    .clr_en       (ret_hit),
    .clr_tag      (bus.mem_tag),
    .lookup_tag   (bus.mem_tag),
    .lookup_entry (ret_entry),
    .count        (outstanding_cnt)
  );

  assign ret_hit             = bus.mem_tag != '0 && ret_entry.valid;
  assign orphan_tag          = bus.mem_tag != '0 && !ret_entry.valid;
  assign bus.icache_tag      = (ret_hit && ret_entry.owner == REQ_ICACHE) ? bus.mem_tag : '0;
  assign bus.dcache_tag      = (ret_hit && ret_entry.owner == REQ_DCACHE) ? bus.mem_tag : '0;
  assign bus.icache_mem_data = bus.mem_data;
  assign bus.dcache_mem_data = bus.mem_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table for single-cycle
// behaviour, then starvation, same-tag collision and reset sequences.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] outstanding_cnt;
  logic       orphan_tag;
  int         n_cmp  = 0;
  int         n_fail = 0;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .outstanding_cnt (outstanding_cnt),
    .orphan_tag      (orphan_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    bus_command_e icmd;
    logic [63:0]  iaddr;
    bus_command_e dcmd;
    logic [63:0]  daddr;
    logic [63:0]  ddata;
    logic [3:0]   resp;
    logic [3:0]   mtag;
    bus_command_e e_cmd;
    logic [63:0]  e_addr;
    logic [63:0]  e_data;
    logic [3:0]   e_iresp;
    logic [3:0]   e_dresp;
    logic [3:0]   e_itag;
    logic [3:0]   e_dtag;
    logic         e_orphan;
    logic [4:0]   e_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bus_command_e icmd, input logic [63:0] iaddr,
                       input bus_command_e dcmd, input logic [63:0] daddr,
                       input logic [63:0] ddata, input logic [3:0] resp,
                       input logic [3:0] mtag);
    bus.icache_command = icmd;
    bus.icache_addr    = iaddr;
    bus.dcache_command = dcmd;
    bus.dcache_addr    = daddr;
    bus.dcache_data    = ddata;
    bus.mem_response   = resp;
    bus.mem_tag        = mtag;
  endtask

  task automatic idle(input logic [3:0] mtag);
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, mtag);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(4'd0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    //          icmd      iaddr         dcmd       daddr         ddata               resp   mtag   e_cmd      e_addr        e_data              e_ir   e_dr   e_it   e_dt   orph  cnt
    vecs[0]  = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0};
    vecs[1]  = '{BUS_LOAD, 64'h1000, BUS_NONE,  64'h0,    64'hAA,         4'd3, 4'd0, BUS_LOAD,  64'h1000, 64'h0,          4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0};
    vecs[2]  = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd1};
    vecs[3]  = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd3, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 5'd1};
    vecs[4]  = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0};
    vecs[5]  = '{BUS_LOAD, 64'h1100, BUS_LOAD,  64'h2200, 64'h55,         4'd5, 4'd0, BUS_LOAD,  64'h2200, 64'h55,         4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 5'd0};
    vecs[6]  = '{BUS_NONE, 64'h0,    BUS_STORE, 64'h2000, 64'hDEADBEEF,   4'd2, 4'd0, BUS_STORE, 64'h2000, 64'hDEADBEEF,   4'd0, 4'd2, 4'd0, 4'd0, 1'b0, 5'd1};
    vecs[7]  = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd2, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 5'd1};
    vecs[8]  = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd5, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 5'd1};
    vecs[9]  = '{BUS_NONE, 64'h0,    BUS_LOAD,  64'h3000, 64'h0,          4'd0, 4'd0, BUS_LOAD,  64'h3000, 64'h0,          4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0};
    vecs[10] = '{BUS_NONE, 64'h0,    BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, BUS_NONE,  64'h0,    64'h0,          4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0};

    bus.mem_data = 64'h0;
    idle(4'd0);
    repeat (2) @(posedge clock);
    #1;
    check("reset cnt", outstanding_cnt, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].icmd, vecs[i].iaddr, vecs[i].dcmd, vecs[i].daddr,
            vecs[i].ddata, vecs[i].resp, vecs[i].mtag);
      bus.mem_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      #4;
      check($sformatf("v%0d cmd", i),    bus.proc2mem_command, vecs[i].e_cmd);
      check($sformatf("v%0d addr", i),   bus.proc2mem_addr,    vecs[i].e_addr);
      check($sformatf("v%0d data", i),   bus.proc2mem_data,    vecs[i].e_data);
      check($sformatf("v%0d iresp", i),  bus.icache_response,  vecs[i].e_iresp);
      check($sformatf("v%0d dresp", i),  bus.dcache_response,  vecs[i].e_dresp);
      check($sformatf("v%0d itag", i),   bus.icache_tag,       vecs[i].e_itag);
      check($sformatf("v%0d dtag", i),   bus.dcache_tag,       vecs[i].e_dtag);
      check($sformatf("v%0d orphan", i), orphan_tag,           vecs[i].e_orphan);
      check($sformatf("v%0d cnt", i),    outstanding_cnt,      vecs[i].e_cnt);
      check($sformatf("v%0d imdata", i), bus.icache_mem_data,  64'hA5A5_0000_0000_0000 | 64'(i));
      check($sformatf("v%0d dmdata", i), bus.dcache_mem_data,  64'hA5A5_0000_0000_0000 | 64'(i));
      tick();
    end

    // Starvation: dcache wins four contended cycles, icache the fifth.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      logic exp_icache;
      exp_icache = (c == 4);
      drive(BUS_LOAD, 64'h4000, BUS_LOAD, 64'h5000, 64'h0, 4'd7, 4'd0);
      #4;
      check($sformatf("starve c%0d addr", c), bus.proc2mem_addr, exp_icache ? 64'h4000 : 64'h5000);
      check($sformatf("starve c%0d iresp", c), bus.icache_response, exp_icache ? 64'd7 : 64'd0);
      check($sformatf("starve c%0d dresp", c), bus.dcache_response, exp_icache ? 64'd0 : 64'd7);
      tick();
    end

    // Same-cycle return and re-issue of tag 4 hands ownership to dcache.
    do_reset();
    drive(BUS_LOAD, 64'h6000, BUS_NONE, 64'h0, 64'h0, 4'd4, 4'd0);
    tick();
    drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h7000, 64'h0, 4'd4, 4'd4);
    #4;
    check("collide itag", bus.icache_tag, 64'd4);
    check("collide dtag", bus.dcache_tag, 64'd0);
    check("collide dresp", bus.dcache_response, 64'd4);
    tick();
    idle(4'd4);
    #4;
    check("reissue dtag", bus.dcache_tag, 64'd4);
    check("reissue itag", bus.icache_tag, 64'd0);
    check("reissue cnt", outstanding_cnt, 64'd1);
    tick();
    idle(4'd0);
    #4;
    check("reissue drained cnt", outstanding_cnt, 64'd0);
    tick();

    // Reset with three loads outstanding; their later returns are orphans.
    do_reset();
    for (int t = 1; t <= 3; t++) begin
      drive(BUS_LOAD, 64'h8000 + 64'(t * 8), BUS_NONE, 64'h0, 64'h0, 4'(t), 4'd0);
      tick();
    end
    idle(4'd0);
    #4;
    check("pre-reset cnt", outstanding_cnt, 64'd3);
    reset = 1'b0;
    #1;
    check("mid-reset cnt", outstanding_cnt, 64'd0);
    drive(BUS_LOAD, 64'h40, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0);
    #1;
    check("in-reset cmd", bus.proc2mem_command, BUS_LOAD);
    check("in-reset addr", bus.proc2mem_addr, 64'h40);
    tick();
    reset = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      idle(4'(t));
      #4;
      check($sformatf("post-reset t%0d orphan", t), orphan_tag, 64'd1);
      check($sformatf("post-reset t%0d itag", t), bus.icache_tag, 64'd0);
      check($sformatf("post-reset t%0d dtag", t), bus.dcache_tag, 64'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
